// File: rtl/user_input_ctrl_if.sv
// CPU-side bundle for the IN-instruction input stage: decode/timer/button/switch
// inputs toward the block and the captured word plus stall back to the core.
interface user_input_ctrl_if;
    logic        inop;
    logic        clk_state;
    logic        bt;
    logic [13:0] in;
    logic [31:0] du;
    logic        await;
    logic        busy;

    modport master (
        output inop, clk_state, bt, in,
        input  du, await, busy
    );

    modport slave (
        input  inop, clk_state, bt, in,
        output du, await, busy
    );
endinterface

// File: rtl/user_input_ctrl.sv
// IN-instruction input stage: synchronises/debounces the button, captures the switch bank
// and stalls the CPU clock until captured. Define USER_INPUT_SIGN_EXT_EN to sign-extend captures.
module user_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic           clk,
    input  logic           bt_reset,
    user_input_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_CAPTURE,
        S_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             bt_s1_q, bt_s2_q;
    logic             cs_s1_q, cs_s2_q, cs_s3_q;
    logic             db_q, db_d, db_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [31:0]      du_q, du_d;
    logic             await_q, await_d;
    logic             busy_q, busy_d;
    logic             press;
    logic             cpu_rise;
    logic [31:0]      capture_word;

`ifdef USER_INPUT_SIGN_EXT_EN
    assign capture_word = {{18{bus.in[13]}}, bus.in};
`else
    assign capture_word = {18'b0, bus.in};
`endif

    assign press    = db_q & ~db_prev_q;
    assign cpu_rise = cs_s2_q & ~cs_s3_q;

    // Counter only runs while the synchronised button disagrees with the debounced level.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (bt_s2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = ~db_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        du_d    = du_q;
        case (state_q)
            S_IDLE: begin
                if (bus.inop) state_d = S_ARM;
            end
            S_ARM: begin
                if (!bus.inop)   state_d = S_IDLE;
                else if (!db_q)  state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!bus.inop) begin
                    state_d = S_IDLE;
                end else if (press) begin
                    state_d = S_CAPTURE;
                    du_d    = capture_word;
                end
            end
            S_CAPTURE: begin
                if (cpu_rise) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!db_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Outputs are registered from the next state so they are glitch-free Moore outputs.
        await_d = (state_d == S_ARM) || (state_d == S_WAIT);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge bt_reset) begin
        if (!bt_reset) begin
            bt_s1_q   <= 1'b0;
            bt_s2_q   <= 1'b0;
            cs_s1_q   <= 1'b0;
            cs_s2_q   <= 1'b0;
            cs_s3_q   <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= S_IDLE;
            du_q      <= '0;
            await_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            bt_s1_q   <= bus.bt;
            bt_s2_q   <= bt_s1_q;
            cs_s1_q   <= bus.clk_state;
            cs_s2_q   <= cs_s1_q;
            cs_s3_q   <= cs_s2_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            du_q      <= du_d;
            await_q   <= await_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.du    = du_q;
    assign bus.await = await_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_user_input_ctrl.sv
// Bench for user_input_ctrl: directed scenarios plus randomized traffic against a phase-level model.
module tb_user_input_ctrl;
    localparam int DB = 4;
    localparam int M_IDLE = 0, M_ARM = 1, M_WAIT = 2, M_CAP = 3, M_REL = 4;

    logic clk = 1'b0;
    logic bt_reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    user_input_ctrl_if bus ();

    user_input_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(16)) dut (
        .clk(clk),
        .bt_reset(bt_reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ext(input logic [13:0] v);
`ifdef USER_INPUT_SIGN_EXT_EN
        return {{18{v[13]}}, v};
`else
        return {18'b0, v};
`endif
    endfunction

    // Reference: the button is seen 2 edges late; the debounced level flips once it has
    // disagreed with the synchronised button on DB consecutive edges.
    int          m_phase, m_run;
    logic [1:0]  m_bt_dly;
    logic [2:0]  m_cs_dly;
    logic        m_db, m_db_last;
    logic [31:0] m_du;
    logic        m_await, m_busy;

    always @(posedge clk or negedge bt_reset) begin
        if (!bt_reset) begin
            m_phase = M_IDLE; m_run = 0; m_bt_dly = '0; m_cs_dly = '0;
            m_db = 0; m_db_last = 0; m_du = '0; m_await = 0; m_busy = 0;
        end else begin
            logic press_now, rise_now, bt_seen;
            press_now = m_db && !m_db_last;
            rise_now  = m_cs_dly[1] && !m_cs_dly[2];
            bt_seen   = m_bt_dly[1];
            case (m_phase)
                M_IDLE: if (bus.inop) m_phase = M_ARM;
                M_ARM:  m_phase = !bus.inop ? M_IDLE : (!m_db ? M_WAIT : M_ARM);
                M_WAIT: begin
                    if (!bus.inop) m_phase = M_IDLE;
                    else if (press_now) begin m_phase = M_CAP; m_du = ext(bus.in); end
                end
                M_CAP:  if (rise_now) m_phase = M_REL;
                default: if (!m_db) m_phase = M_IDLE;
            endcase
            m_await   = (m_phase == M_ARM) || (m_phase == M_WAIT);
            m_busy    = (m_phase != M_IDLE);
            m_db_last = m_db;
            if (bt_seen != m_db) begin
                m_run++;
                if (m_run == DB) begin m_db = !m_db; m_run = 0; end
            end else m_run = 0;
            m_bt_dly = {m_bt_dly[0], bus.bt};
            m_cs_dly = {m_cs_dly[1:0], bus.clk_state};
        end
    end

    // Finish any capture in progress and return to IDLE (no checking here).
    task automatic drain();
        bus.inop = 0; bus.clk_state = 1;
        repeat (4) @(negedge clk);
        bus.clk_state = 0; bus.bt = 0;
        repeat (14) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (bus.du !== 32'h0) begin n_fail++; $display("FAIL reset_du: got %h want 0", bus.du); end
        n_checks++; if (bus.await !== 1'b0) begin n_fail++; $display("FAIL reset_await: got %b want 0", bus.await); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_basic_in();
        int k;
        bus.in = 14'h1234; bus.inop = 1; bus.bt = 0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.await !== 1'b1) begin n_fail++; $display("FAIL basic_await_rise: got %b want 1", bus.await); end
        bus.bt = 1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 6) begin
                n_checks++; if (bus.await !== 1'b1) begin n_fail++; $display("FAIL basic_early: await %b want 1", bus.await); end
            end
            if (i == 7) begin
                n_checks++; if (bus.du !== 32'h0000_1234) begin n_fail++; $display("FAIL basic_du: got %h want 00001234", bus.du); end
                n_checks++; if (bus.await !== 1'b0) begin n_fail++; $display("FAIL basic_await_fall: got %b want 0", bus.await); end
                bus.inop = 0;
            end
        end
        bus.clk_state = 1;
        repeat (4) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b1 || bus.await !== 1'b0) begin
            n_fail++; $display("FAIL basic_release: busy %b await %b want 1/0", bus.busy, bus.await); end
        bus.clk_state = 0; bus.bt = 0;
        k = 0;
        while (bus.busy !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: busy %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        bus.inop = 1;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.await !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL rmid_wait: await %b busy %b want 1/1", bus.await, bus.busy); end
        #1 bt_reset = 0;
        #1;
        n_checks++; if (bus.du !== 32'h0) begin n_fail++; $display("FAIL rmid_du: got %h want 0", bus.du); end
        n_checks++; if (bus.await !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL rmid_out: await %b busy %b want 0/0", bus.await, bus.busy); end
        bus.inop = 0;
        #1 bt_reset = 1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_idle: busy %b want 0", bus.busy); end
    endtask

    task automatic test_bounce();
        logic [13:0] v;
        int k;
        v = 14'($urandom);
        bus.inop = 1; bus.in = v;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) bus.bt = ((i / 2) % 2 == 0);
            @(negedge clk);
            n_checks++; if (bus.await !== 1'b1) begin n_fail++; $display("FAIL bounce_hold[%0d]: await %b want 1", i, bus.await); end
        end
        bus.bt = 1;
        k = 0;
        while (bus.await !== 1'b0 && k < 15) begin @(negedge clk); k++; end
        n_checks++; if (bus.du !== ext(v)) begin n_fail++; $display("FAIL bounce_du: got %h want %h", bus.du, ext(v)); end
        bus.in = ~v;
        repeat (6) @(negedge clk);
        n_checks++; if (bus.du !== ext(v) || bus.await !== 1'b0) begin
            n_fail++; $display("FAIL bounce_single: du %h await %b want %h/0", bus.du, bus.await, ext(v)); end
        drain();
    endtask

    task automatic test_held();
        int k;
        bus.inop = 1; bus.in = 14'h0003;
        repeat (3) @(negedge clk);
        bus.bt = 1;
        k = 0;
        while (bus.await !== 1'b0 && k < 15) begin @(negedge clk); k++; end
        n_checks++; if (bus.du !== 32'h3) begin n_fail++; $display("FAIL held_first: du %h want 3", bus.du); end
        bus.inop = 0; bus.clk_state = 1;
        repeat (4) @(negedge clk);
        bus.clk_state = 0; bus.inop = 1; bus.in = 14'h0005;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++; if (bus.busy !== 1'b1 || bus.await !== 1'b0 || bus.du !== 32'h3) begin
                n_fail++; $display("FAIL held_stuck[%0d]: busy %b await %b du %h want 1/0/3", i, bus.busy, bus.await, bus.du); end
        end
        bus.bt = 0;
        k = 0;
        while (bus.await !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        n_checks++; if (bus.await !== 1'b1) begin n_fail++; $display("FAIL held_rearm: await %b want 1", bus.await); end
        repeat (2) @(negedge clk);
        bus.bt = 1;
        k = 0;
        while (bus.await !== 1'b0 && k < 15) begin @(negedge clk); k++; end
        n_checks++; if (bus.du !== 32'h5) begin n_fail++; $display("FAIL held_fresh: du %h want 5", bus.du); end
        drain();
    endtask

    task automatic test_abort();
        bus.inop = 1; bus.in = 14'h3FFF;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.await !== 1'b1) begin n_fail++; $display("FAIL abort_wait: await %b want 1", bus.await); end
        bus.inop = 0;
        @(negedge clk);
        n_checks++; if (bus.await !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle: await %b busy %b want 0/0", bus.await, bus.busy); end
        n_checks++; if (bus.du !== 32'h5) begin n_fail++; $display("FAIL abort_du: got %h want 5", bus.du); end
    endtask

    task automatic test_sign_ext();
        int k;
        logic [31:0] want;
`ifdef USER_INPUT_SIGN_EXT_EN
        want = 32'hFFFF_E001;
`else
        want = 32'h0000_2001;
`endif
        bus.inop = 1; bus.in = 14'h2001;
        repeat (3) @(negedge clk);
        bus.bt = 1;
        k = 0;
        while (bus.await !== 1'b0 && k < 15) begin @(negedge clk); k++; end
        n_checks++; if (bus.du !== want) begin n_fail++; $display("FAIL sign_ext: du %h want %h", bus.du, want); end
        drain();
    endtask

    task automatic test_random();
        int bt_hold = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            n_checks++; if (bus.du !== m_du) begin n_fail++; $display("FAIL rand_du @%0d: got %h want %h", c, bus.du, m_du); end
            n_checks++; if (bus.await !== m_await) begin n_fail++; $display("FAIL rand_await @%0d: got %b want %b", c, bus.await, m_await); end
            n_checks++; if (bus.busy !== m_busy) begin n_fail++; $display("FAIL rand_busy @%0d: got %b want %b", c, bus.busy, m_busy); end
            if (bt_hold == 0) begin
                bus.bt = 1'($urandom);
                bt_hold = $urandom_range(1, 10);
            end
            bt_hold--;
            if ($urandom_range(0, 15) == 0) bus.inop = ~bus.inop;
            if ($urandom_range(0, 5) == 0) bus.clk_state = ~bus.clk_state;
            bus.in = 14'($urandom);
        end
    endtask

    initial begin
        bus.inop = 0; bus.clk_state = 0; bus.bt = 0; bus.in = '0;
        #1 bt_reset = 0;
        #12 bt_reset = 1;
        test_reset();
        test_basic_in();
        test_reset_mid();
        test_bounce();
        test_held();
        test_abort();
        test_sign_ext();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
